// File: rtl/tick_burst_gen.sv
// Programmable enable-pulse generator: divides clk by div+1 and issues single-cycle en pulses,
// either continuously or as a fixed-length burst that ends with a coincident done pulse.
module tick_burst_gen #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] burst_len,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_cnt
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e             state_q;
  logic [DIV_W-1:0]   presc_q;
  logic [DIV_W-1:0]   div_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   tick_cnt_q;
  logic               en_q;
  logic               done_q;
  logic [CNT_W-1:0]   tick_next;

  always_comb begin
    tick_next = tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      div_q      <= '0;
      len_q      <= '0;
      tick_cnt_q <= '0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          en_q   <= 1'b0;
          done_q <= 1'b0;
          // A simultaneous stop vetoes the start; nothing is latched.
          if (start && !stop) begin
            div_q      <= div;
            len_q      <= burst_len;
            presc_q    <= '0;
            tick_cnt_q <= '0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          if (stop) begin
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            state_q <= StIdle;
          end else if (hold) begin
            en_q   <= 1'b0;
            done_q <= 1'b0;
          end else if (presc_q == div_q) begin
            presc_q    <= '0;
            en_q       <= 1'b1;
            tick_cnt_q <= tick_next;
            // len_q == 0 selects continuous mode, which never completes.
            if ((len_q != '0) && (tick_next == len_q)) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              done_q <= 1'b0;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          en_q    <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign en       = en_q;
  assign done     = done_q;
  assign tick_cnt = tick_cnt_q;
  assign busy     = (state_q == StRun);

endmodule

// File: tb/tb_tick_burst_gen.sv
// Directed bench for tick_burst_gen: outputs are sampled 1 time unit after each rising edge and
// compared against hand-computed values.
module tb_tick_burst_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       hold;
  logic [7:0] div;
  logic [5:0] burst_len;
  logic       en;
  logic       busy;
  logic       done;
  logic [5:0] tick_cnt;

  int n_vec;
  int n_err;
  int en_seen;

  tick_burst_gen #(
    .DIV_W(8),
    .CNT_W(6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .hold     (hold),
    .div      (div),
    .burst_len(burst_len),
    .en       (en),
    .busy     (busy),
    .done     (done),
    .tick_cnt (tick_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Burst div=3, len=4 after the start edge E0: en after E4/E8/E12/E16, done with the last.
  // Optionally pulses start during the run to show it is ignored.
  task automatic burst_div3_len4(input bit poke_start);
    en_seen = 0;
    for (int k = 1; k <= 16; k++) begin
      start = (poke_start && k >= 5 && k <= 8);
      step();
      if (en) en_seen++;
      check($sformatf("burst_en_k%0d", k), {31'b0, en}, {31'b0, (k % 4 == 0)});
      check($sformatf("burst_done_k%0d", k), {31'b0, done}, {31'b0, (k == 16)});
      check($sformatf("burst_busy_k%0d", k), {31'b0, busy}, {31'b0, (k < 16)});
      if (k == 8) check("burst_tick_k8", {26'b0, tick_cnt}, 32'd2);
    end
    start = 1'b0;
    check("burst_tick_final", {26'b0, tick_cnt}, 32'd4);
    check("burst_counter_steps", en_seen, 32'd4);
    step();
    check("burst_idle_en", {31'b0, en}, 32'd0);
    check("burst_idle_done", {31'b0, done}, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    hold = 1'b0;
    div = 8'd3;
    burst_len = 6'd0;
    #12;
    check("rst_en", {31'b0, en}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_tick", {26'b0, tick_cnt}, 32'd0);
    rst = 1'b1;
    step();
    check("post_rst_busy", {31'b0, busy}, 32'd0);

    // Reset mid-run, asserted right after en rises at E4.
    div = 8'd3; burst_len = 6'd0; start = 1'b1;
    step();
    start = 1'b0;
    check("mr_busy", {31'b0, busy}, 32'd1);
    for (int k = 1; k <= 4; k++) step();
    check("mr_en_before", {31'b0, en}, 32'd1);
    check("mr_tick_before", {26'b0, tick_cnt}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("mr_en_async", {31'b0, en}, 32'd0);
    check("mr_busy_async", {31'b0, busy}, 32'd0);
    check("mr_tick_async", {26'b0, tick_cnt}, 32'd0);
    check("mr_done_async", {31'b0, done}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("mr_en_held", {31'b0, en}, 32'd0);
      check("mr_busy_held", {31'b0, busy}, 32'd0);
    end
    #2 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("mr_en_idle", {31'b0, en}, 32'd0);
      check("mr_busy_idle", {31'b0, busy}, 32'd0);
    end

    // Basic burst.
    div = 8'd3; burst_len = 6'd4; start = 1'b1;
    step();
    start = 1'b0;
    check("b_start_busy", {31'b0, busy}, 32'd1);
    check("b_start_tick", {26'b0, tick_cnt}, 32'd0);
    burst_div3_len4(1'b0);

    // Full rate, single pulse.
    div = 8'd0; burst_len = 6'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("fr1_en", {31'b0, en}, 32'd1);
    check("fr1_done", {31'b0, done}, 32'd1);
    check("fr1_busy", {31'b0, busy}, 32'd0);
    check("fr1_tick", {26'b0, tick_cnt}, 32'd1);
    step();
    check("fr1_en_after", {31'b0, en}, 32'd0);

    // Full rate, 63 back-to-back pulses.
    burst_len = 6'd63; start = 1'b1;
    step();
    start = 1'b0;
    en_seen = 0;
    for (int k = 1; k <= 63; k++) begin
      step();
      if (en) en_seen++;
      if (k == 62) check("fr63_done_early", {31'b0, done}, 32'd0);
    end
    check("fr63_en_count", en_seen, 32'd63);
    check("fr63_done", {31'b0, done}, 32'd1);
    check("fr63_tick", {26'b0, tick_cnt}, 32'd63);
    check("fr63_busy", {31'b0, busy}, 32'd0);
    step();
    check("fr63_en_after", {31'b0, en}, 32'd0);
    check("fr63_tick_held", {26'b0, tick_cnt}, 32'd63);

    // Continuous mode for 140 cycles: 70 pulses, tick_cnt wraps to 6.
    div = 8'd1; burst_len = 6'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 140; k++) begin
      step();
      check($sformatf("cont_en_k%0d", k), {31'b0, en}, {31'b0, (k % 2 == 0)});
      check($sformatf("cont_done_k%0d", k), {31'b0, done}, 32'd0);
      if (k == 126) check("cont_tick_63", {26'b0, tick_cnt}, 32'd63);
      if (k == 128) check("cont_tick_wrap", {26'b0, tick_cnt}, 32'd0);
    end
    check("cont_busy", {31'b0, busy}, 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("cont_stop_busy", {31'b0, busy}, 32'd0);
    check("cont_stop_en", {31'b0, en}, 32'd0);
    check("cont_stop_done", {31'b0, done}, 32'd0);
    check("cont_stop_tick", {26'b0, tick_cnt}, 32'd6);

    // Hold for 7 edges (E3..E9) delays the first pulse from E5 to E12.
    div = 8'd4; burst_len = 6'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      hold = (k >= 3 && k <= 9);
      step();
      check($sformatf("hold_en_k%0d", k), {31'b0, en}, {31'b0, (k == 12)});
    end
    hold = 1'b0;
    check("hold_tick", {26'b0, tick_cnt}, 32'd1);
    for (int k = 13; k <= 16; k++) begin
      step();
      check("hold_gap_en", {31'b0, en}, 32'd0);
    end
    // E17 would issue the second pulse; stop+hold wins.
    stop = 1'b1; hold = 1'b1;
    step();
    stop = 1'b0; hold = 1'b0;
    check("sh_en", {31'b0, en}, 32'd0);
    check("sh_done", {31'b0, done}, 32'd0);
    check("sh_busy", {31'b0, busy}, 32'd0);
    check("sh_tick", {26'b0, tick_cnt}, 32'd1);

    // Shadowing: div/burst_len changed after start, plus start poked mid-run.
    div = 8'd3; burst_len = 6'd4; start = 1'b1;
    step();
    start = 1'b0;
    div = 8'd0; burst_len = 6'd1;
    burst_div3_len4(1'b1);

    // start+stop together in IDLE.
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", {31'b0, busy}, 32'd0);
    check("ss_tick", {26'b0, tick_cnt}, 32'd4);
    step();
    check("ss_en", {31'b0, en}, 32'd0);
    check("ss_busy2", {31'b0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
